// File: rtl/roulette_pkg.sv
// roulette_pkg: sequencer state type, default counter width and saturating delay update
package roulette_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, REQ, HOLD} state_t;
  localparam int CNT_W_DEF = 32;
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input logic [63:0] lim);
    logic [63:0] s;
    s = a + b;
    return (s < a || s > lim) ? lim : s;
  endfunction
endpackage

// File: rtl/roulette_sequencer_key_debounce.sv
// key_debounce: 2-flop sync, stable-sample filter and one-cycle press pulse for an active-low key
//   i_clk, i_rst_n (async active-low), i_key (raw, active-low), o_press (pulse on accepted press)
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
)(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_press
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  logic [1:0] sync;
  logic level, level_q;
  logic [DW-1:0] cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      sync <= 2'b11;
      level <= 1'b1;
      level_q <= 1'b1;
      cnt <= '0;
      o_press <= 1'b0;
    end else begin
      sync <= {sync[0], i_key};
      level_q <= level;
      o_press <= level_q & ~level;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == DW'(DEBOUNCE_CYC - 1)) begin
        level <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + DW'(1);
    end
endmodule

// File: rtl/roulette_sequencer.sv
// roulette_sequencer: debounced KEY start/stop and decelerating generator-advance scheduler
//   i_clk, i_rst_n (async active-low), i_start (raw active-low key), i_step_ack (advance consumed)
//   o_step_req (advance request), o_show (display enable), o_final (result held), o_run_idx[4:0],
//   o_done (pulse on reaching HOLD), o_err (sticky ack timeout)
//   SEQ_TIMEOUT_EN: abort REQ to IDLE with o_err after ACK_TIMEOUT unacknowledged cycles
module roulette_sequencer
  import roulette_pkg::*;
#(
  parameter int STEP_COUNT   = 15,
  parameter int BASE_DELAY   = 4000000,
  parameter int DELAY_INC    = 2000000,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = CNT_W_DEF
`ifdef SEQ_TIMEOUT_EN
  , parameter int ACK_TIMEOUT = 1024
`endif
)(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_step_ack,
  output logic       o_step_req,
  output logic       o_show,
  output logic       o_final,
  output logic [4:0] o_run_idx,
  output logic       o_done,
  output logic       o_err
);
  localparam logic [CNT_W-1:0] BASE_EFF = (BASE_DELAY == 0) ? CNT_W'(1) : CNT_W'(BASE_DELAY);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, delay, delay_n;
  logic [4:0] idx, idx_n;
  logic done_n, press;
`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tmo, tmo_n;
  logic err_n;
`endif
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_key(i_start), .o_press(press)
  );
  assign o_step_req = state == REQ;
  assign o_show = state != IDLE;
  assign o_final = state == HOLD;
  assign o_run_idx = idx;
  always_comb begin
    state_n = state;
    cnt_n = '0;
    delay_n = delay;
    idx_n = idx;
    done_n = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    tmo_n = '0;
    err_n = press ? 1'b0 : o_err;
`endif
    unique case (state)
      IDLE:
        if (press) begin
          state_n = WAIT;
          delay_n = BASE_EFF;
          idx_n = '0;
        end
      WAIT:
        if (press) begin
          state_n = IDLE;
          idx_n = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          state_n = (cnt == delay - CNT_W'(1)) ? REQ : WAIT;
        end
      REQ: begin
        if (press) begin
          state_n = IDLE;
          idx_n = '0;
        end else if (i_step_ack) begin
          idx_n = idx + 5'd1;
          if (idx_n == 5'(STEP_COUNT)) begin
            state_n = HOLD;
            done_n = 1'b1;
          end else begin
            state_n = WAIT;
            delay_n = CNT_W'(sat_add(64'(delay), 64'(DELAY_INC), 64'({CNT_W{1'b1}})));
          end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (tmo == TW'(ACK_TIMEOUT - 1)) begin
          state_n = IDLE;
          idx_n = '0;
          err_n = 1'b1;
        end else tmo_n = tmo + TW'(1);
`endif
      end
      HOLD:
        if (press) begin
          state_n = IDLE;
          idx_n = '0;
        end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      delay <= BASE_EFF;
      idx <= '0;
      o_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      delay <= delay_n;
      idx <= idx_n;
      o_done <= done_n;
    end
`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      tmo <= '0;
      o_err <= 1'b0;
    end else begin
      tmo <= tmo_n;
      o_err <= err_n;
    end
`else
  assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_roulette_sequencer.sv
// tb_roulette_sequencer: randomized key/ack stimulus checked cycle by cycle against a behavioural model
module tb_roulette_sequencer;
  localparam int STEP = 4, BASE = 10, INC = 5, DEB = 3;
  localparam int M_IDLE = 0, M_WAIT = 1, M_REQ = 2, M_HOLD = 3;
`ifdef SEQ_TIMEOUT_EN
  localparam int TMO = 8;
`endif
  logic clk = 1'b0, rst_n = 1'b0, key = 1'b1, ack = 1'b0;
  logic req, show, fin, done, err;
  logic [4:0] idx;
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;
  roulette_sequencer #(
    .STEP_COUNT(STEP), .BASE_DELAY(BASE), .DELAY_INC(INC), .DEBOUNCE_CYC(DEB)
`ifdef SEQ_TIMEOUT_EN
    , .ACK_TIMEOUT(TMO)
`endif
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(key), .i_step_ack(ack),
    .o_step_req(req), .o_show(show), .o_final(fin), .o_run_idx(idx), .o_done(done), .o_err(err)
  );
  int m_phase, m_waited, m_idx, m_reqage;
  bit m_done, m_err, m_lvl, m_pend, m_pvis;
  bit hist[$];
  bit kq[$];
  int ack_mode, ack_dly;
  int cyc = 0, show_rise, ndone, wcur;
  int rises[$], widths[$];
  bit req_q, show_q;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_phase = M_IDLE; m_waited = 0; m_idx = 0; m_reqage = 0;
    m_done = 0; m_err = 0; m_lvl = 1; m_pend = 0; m_pvis = 0;
    hist.delete();
    repeat (DEB + 2) hist.push_front(1'b1);
  endtask
  task automatic model_step();
    bit p, flip, fall;
    p = m_pvis;
    hist.push_front(key);
    void'(hist.pop_back());
    flip = 1;
    for (int j = 0; j < DEB; j++) if (hist[2 + j] == m_lvl) flip = 0;
    fall = flip && m_lvl;
    if (flip) m_lvl = !m_lvl;
    m_pvis = m_pend;
    m_pend = fall;
    m_done = 0;
    if (p) m_err = 0;
    case (m_phase)
      M_IDLE: if (p) begin m_phase = M_WAIT; m_waited = 0; m_idx = 0; end
      M_WAIT:
        if (p) begin m_phase = M_IDLE; m_idx = 0; end
        else begin
          m_waited++;
          if (m_waited == BASE + m_idx * INC) begin m_phase = M_REQ; m_reqage = 0; end
        end
      M_REQ:
        if (p) begin m_phase = M_IDLE; m_idx = 0; end
        else if (ack) begin
          m_idx++;
          if (m_idx == STEP) begin m_phase = M_HOLD; m_done = 1; end
          else begin m_phase = M_WAIT; m_waited = 0; end
        end else begin
          m_reqage++;
`ifdef SEQ_TIMEOUT_EN
          if (m_reqage == TMO) begin m_phase = M_IDLE; m_idx = 0; m_err = 1; end
`endif
        end
      default: if (p) begin m_phase = M_IDLE; m_idx = 0; end
    endcase
  endtask
  task automatic obs_clear();
    rises.delete(); widths.delete();
    show_rise = -1; ndone = 0; wcur = 0;
  endtask
  task automatic tick();
    key = kq.size() != 0 ? kq.pop_front() : 1'b1;
    ack = ack_mode == 0 ? 1'b1 :
          ack_mode == 1 ? (m_phase == M_REQ && m_reqage >= ack_dly) :
          ack_mode == 2 ? ($urandom_range(0, 3) == 0) : 1'b0;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("req", req, m_phase == M_REQ);
    check("show", show, m_phase != M_IDLE);
    check("final", fin, m_phase == M_HOLD);
    check("run_idx", idx, m_idx);
    check("done", done, m_done);
    check("err", err, m_err);
    if (req && !req_q) rises.push_back(cyc);
    if (req) wcur++;
    else if (req_q) begin widths.push_back(wcur); wcur = 0; end
    if (show && !show_q) show_rise = cyc;
    if (done) ndone++;
    req_q = req; show_q = show; cyc++;
  endtask
  task automatic press(input bit bounce);
    if (bounce) for (int i = 0; i < 5; i++) begin
      kq.push_back(0); kq.push_back(0); kq.push_back(1); kq.push_back(1);
    end
    repeat (DEB + 4 + $urandom_range(0, 3)) kq.push_back(0);
    repeat (DEB + 3) kq.push_back(1);
  endtask
  task automatic drain();
    while (kq.size() != 0) tick();
  endtask
  task automatic to_idle();
    for (int i = 0; i < 3 && m_phase != M_IDLE; i++) begin press(0); drain(); end
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", req, 0); check("arst_show", show, 0); check("arst_final", fin, 0);
    check("arst_idx", idx, 0); check("arst_done", done, 0); check("arst_err", err, 0);
    kq.delete(); key = 1'b1; ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    req_q = 0; show_q = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int t_low;
    m_reset(); obs_clear(); ack_mode = 0; ack_dly = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", req, 0); check("rst_show", show, 0); check("rst_idx", idx, 0);
    rst_n = 1'b1;
    repeat (4) tick();
    obs_clear();
    for (int i = 0; i < 5; i++) begin kq.push_back(0); kq.push_back(0); kq.push_back(1); kq.push_back(1); end
    t_low = cyc + 20;
    repeat (DEB + 6) kq.push_back(0);
    repeat (DEB + 3) kq.push_back(1);
    for (int t = 0; t < 60 && show_rise < 0; t++) tick();
    check("press_lat", show_rise - t_low, DEB + 3);
    drain(); to_idle();
    ack_mode = 0; obs_clear(); press(0);
    for (int t = 0; t < 400 && !fin; t++) tick();
    check("full_final", fin, 1);
    check("full_idx", idx, STEP);
    check("full_done", ndone, 1);
    check("full_reqs", rises.size(), STEP);
    if (rises.size() == STEP) begin
      check("first_wait", rises[0] - show_rise, BASE);
      for (int k = 1; k < STEP; k++) check("wait_gap", rises[k] - rises[k - 1] - 1, BASE + k * INC);
    end
    press(0);
    for (int t = 0; t < 60 && show; t++) tick();
    check("hold_exit_final", fin, 0);
    check("hold_exit_show", show, 0);
    drain();
    ack_mode = 1; ack_dly = 2; obs_clear(); press(0);
    for (int t = 0; t < 600 && !fin; t++) tick();
    check("dly_reqs", widths.size(), STEP);
    for (int k = 0; k < widths.size(); k++) check("dly_width", widths[k], ack_dly + 1);
    for (int k = 1; k < rises.size(); k++) check("dly_gap", rises[k] - rises[k - 1] - 3, BASE + k * INC);
    drain(); to_idle();
    ack_mode = 0; obs_clear(); press(0);
    for (int t = 0; t < 200 && !(m_phase == M_WAIT && m_idx == 1); t++) tick();
    press(0);
    for (int t = 0; t < 60 && show; t++) tick();
    check("abort_show", show, 0);
    check("abort_idx", idx, 0);
    drain();
    obs_clear(); press(0);
    for (int t = 0; t < 100 && rises.size() == 0; t++) tick();
    check("restart_wait", rises.size() != 0 ? rises[0] - show_rise : -1, BASE);
    drain(); to_idle();
`ifdef SEQ_TIMEOUT_EN
    ack_mode = 3; obs_clear(); press(0);
    for (int t = 0; t < 200 && !err; t++) tick();
    check("tmo_err", err, 1);
    check("tmo_show", show, 0);
    check("tmo_width", widths.size() != 0 ? widths[0] : -1, TMO);
    drain();
    ack_mode = 0; press(0); drain();
    check("tmo_clear", err, 0);
    to_idle();
`endif
    repeat (8) begin
      ack_mode = $urandom_range(0, 2);
      ack_dly = $urandom_range(0, 4);
      press(1'($urandom_range(0, 1)));
      repeat ($urandom_range(20, 160)) tick();
      drain();
    end
    ack_mode = 2; press(0);
    repeat (30) tick();
    do_reset();
    repeat (20) tick();
    press(0); drain();
    repeat (40) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
